axi_byte_reader: RTL and testbench
==================================

# axi_byte_reader

AXI4-Lite read initiator that fetches a contiguous run of bytes from a byte-per-beat AXI memory responder and presents them as a valid/ready byte stream with a last marker. It sits between the layer-test control sequencer and the weight/input memory model. It feeds the first-layer datapath one byte at a time. It keeps at most one read outstanding and never issues a read whose result it has no buffer space for.

## Interface
- ADDR_W, 32, AXI address width
- LEN_W, 16, width of transfer byte count
- STRIDE, 1, address increment per beat (bytes)
- FIFO_DEPTH, 2, output buffer entries (power of two, ≥2)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first byte address, latched on start
- len  in  LEN_W  byte count, latched on start; 0 allowed
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at end of transfer
- err  out  1  sticky: any RRESP≠OKAY seen; cleared on accepted start
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_ARADDR  out  ADDR_W  read address
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready
- M_AXI_RDATA  in  32  read data; only [7:0] used
- M_AXI_RRESP  in  2  read response
- out_valid  out  1  stream byte valid
- out_ready  in  1  stream consumer ready
- out_data  out  8  stream byte
- out_last  out  1  marks final byte of transfer

## Operation
- States: IDLE, ADDR, RESP, FLUSH.
- IDLE: start with len≠0 → latch addr/len, remaining=len, clear err → ADDR. Start with len=0 → clear err, done pulse next cycle, stay IDLE. Start outside IDLE ignored.
- ADDR: ARVALID asserted only when fifo_count + 0 outstanding < FIFO_DEPTH; once asserted, ARVALID and ARADDR held stable until ARREADY. On handshake: addr += STRIDE (wraps mod 2^ADDR_W), remaining−1 → RESP.
- RESP: RREADY=1 (slot reserved). On RVALID: push {RDATA[7:0], last=(remaining==0)} into FIFO; RRESP≠2'b00 sets err, byte still delivered. Then remaining≠0 → ADDR, else → FLUSH.
- FLUSH: wait for out handshake of the last-flagged byte → done pulse, → IDLE.
- Exactly one AR per byte; never two outstanding (responder may overwrite on second AR).
- Outputs are FIFO head; out_last is the stored flag.
- Reset (any time): all state cleared, FIFO flushed, outstanding read abandoned.

## Timing
- Reset values: busy=0, done=0, err=0, ARVALID=0, ARADDR=0, RREADY=0, out_valid=0, out_data=0, out_last=0.
- All outputs registered except out_* (FIFO head, registered storage).
- Start at cycle 0 → ARVALID=1, ARADDR=base at cycle 1.
- With zero-wait responder (ARREADY=1, RVALID one cycle after AR): AR handshake at cycle 1, R handshake at cycle 2, out_valid at cycle 3, next ARVALID at cycle 3. Steady rate is one byte per 2 cycles.
- Done pulses the cycle after the last out handshake; busy falls in that same cycle.
- RREADY deasserts the cycle after R handshake.
- Full FIFO with a push and pop in the same cycle: both occur and the count is unchanged.

## Structure
- Shared package axi_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, reader state encoding.
- Sub-module byte_fifo: synchronous FIFO, 9-bit entries {last, data}, parameter FIFO_DEPTH, full/empty/count outputs.
- The FSM, address/remaining counters, and err flag live in the top module.

## Test plan
- Memory preloaded mem[i]=i, start base=0x10 len=4, out_ready=1 → stream 0x10,0x11,0x12,0x13, out_last only on 0x13, one done pulse, ARADDRs 0x10–0x13 each exactly once.
- len=0 start → no ARVALID, done pulses once, busy stays 0.
- out_ready held low 20 cycles, len=8 → at most FIFO_DEPTH AR handshakes before first pop, then all 8 bytes in order, none lost or duplicated.
- Responder with ARREADY delayed 3 cycles → ARVALID/ARADDR stable throughout wait, data correct.
- RRESP=2'b10 on beat 2 of 4 → err=1 after that beat, all 4 bytes delivered; next start clears err.
- rst_n pulsed low mid-transfer, then start while busy on a fresh run → all outputs at reset values, new run correct, mid-busy start ignored.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response codes, byte reader state encoding and FIFO entry layout.
// Pure declarations: no latency, no flow control.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RESP,
    S_FLUSH
  } reader_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } byte_entry_t;

  // Anything other than plain OKAY counts as an error for this reader, EXOKAY included.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic is_err;
    is_err = 1'b1;
    case (resp)
      RESP_OKAY:                            is_err = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: is_err = 1'b1;
      default:                              is_err = 1'b1;
    endcase
    return is_err;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO of {last, data} entries; a push becomes visible at the head one cycle later.
// Push is dropped only when full with no pop; push and pop on a full FIFO both take effect.
module byte_fifo
  import axi_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  byte_entry_t                   push_data,
  input  logic                          pop,
  output byte_entry_t                   pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  byte_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_fire;
  logic             pop_fire;

  assign full      = (cnt == CNT_W'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign push_fire = push && (!full || pop);
  assign pop_fire  = pop && !empty;
  assign pop_data  = mem[rd_ptr];
  assign count     = cnt;

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

endmodule

// File: rtl/axi_byte_reader.sv
// AXI4-Lite byte reader: one AR per byte, single outstanding read, bytes streamed out through byte_fifo.
// Latency start->ARVALID 1 cycle, R->out_valid 1 cycle; ARVALID is withheld while the FIFO has no free slot.
module axi_byte_reader
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int STRIDE     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reader_state_e     state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic              ar_fire, r_fire, pop_fire, push;
  byte_entry_t       push_entry, head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt, cnt_after;
  logic              unused_rdata;

  assign ar_fire      = arvalid_q && M_AXI_ARREADY;
  assign r_fire       = rready_q && M_AXI_RVALID;
  assign pop_fire     = !fifo_empty && out_ready;
  assign push_entry   = '{last: (rem_q == '0), data: M_AXI_RDATA[7:0]};
  assign cnt_after    = fifo_cnt + CNT_W'(1) - CNT_W'(pop_fire);
  assign unused_rdata = ^M_AXI_RDATA[31:8];

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rem_d     = rem_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // FIFO is always drained in IDLE, so the first AR can go out immediately.
        if (start) begin
          err_d = 1'b0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            araddr_d  = base_addr;
            rem_d     = len;
            busy_d    = 1'b1;
            arvalid_d = 1'b1;
            state_d   = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          araddr_d  = araddr_q + ADDR_W'(STRIDE);
          rem_d     = rem_q - LEN_W'(1);
          rready_d  = 1'b1;
          state_d   = S_RESP;
        end else if (!arvalid_q) begin
          arvalid_d = !fifo_full;
        end
      end
      S_RESP: begin
        if (r_fire) begin
          push     = 1'b1;
          rready_d = 1'b0;
          if (resp_is_err(M_AXI_RRESP)) err_d = 1'b1;
          if (rem_q != '0) begin
            // Reserve a slot for the next byte against the post-push occupancy.
            arvalid_d = (cnt_after < CNT_W'(FIFO_DEPTH));
            state_d   = S_ADDR;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (pop_fire && head.last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rem_q     <= '0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rem_q     <= rem_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (out_ready),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_RREADY  = rready_q;
  assign out_valid     = !fifo_empty;
  assign out_data      = head.data;
  assign out_last      = head.last;

endmodule

// File: tb/tb_axi_byte_reader.sv
// Bench for axi_byte_reader: AXI responder with mem[a] = a[7:0], stream/AR logs checked against a reference.
module tb_axi_byte_reader;

  localparam int STRIDE = 1;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;

  axi_byte_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  int ar_delay, err_beat, ar_wait;
  int cyc = 0, done_cnt, done_cyc, start_cyc, first_ar, first_pop, proto_err;
  logic busy_seen, busy_at_done, rdy_rand;
  logic ar_hold, r_prev;
  logic [31:0] ar_held;
  logic [31:0] ar_log[$];
  logic [8:0]  out_log[$];
  logic        err_at_pop[$];

  // Reference: byte i of a run is the byte stored at base + i*STRIDE, flagged last only at i == len-1.
  function automatic logic [8:0] ref_entry(input logic [31:0] b, input int l, input int i);
    logic [31:0] a;
    a = b + 32'(i * STRIDE);
    return {(i == l - 1), a[7:0]};
  endfunction

  assign M_AXI_ARREADY = (ar_wait >= ar_delay);

  // Responder: R beat one cycle after each AR handshake, garbage in RDATA[31:8].
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_AXI_RVALID <= 1'b0;
      M_AXI_RDATA  <= '0;
      M_AXI_RRESP  <= 2'b00;
      ar_wait      <= 0;
    end else begin
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (M_AXI_RVALID && !M_AXI_RREADY) proto_err++;
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= {24'($urandom), M_AXI_ARADDR[7:0]};
        M_AXI_RRESP  <= (ar_log.size() == err_beat) ? 2'b10 : 2'b00;
        ar_log.push_back(M_AXI_ARADDR);
        if (first_ar < 0) first_ar = cyc;
        ar_wait <= 0;
      end else if (M_AXI_ARVALID) begin
        ar_wait <= ar_wait + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_log.push_back({out_last, out_data});
        err_at_pop.push_back(err);
        if (first_pop < 0) first_pop = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
      if (busy) busy_seen = 1'b1;
      if (start && start_cyc < 0) start_cyc = cyc;
      if (ar_hold && !(M_AXI_ARVALID && M_AXI_ARADDR == ar_held)) proto_err++;
      ar_hold = M_AXI_ARVALID && !M_AXI_ARREADY;
      ar_held = M_AXI_ARADDR;
      if (r_prev && M_AXI_RREADY) proto_err++;
      r_prev = M_AXI_RVALID && M_AXI_RREADY;
    end else begin
      ar_hold = 1'b0;
      r_prev  = 1'b0;
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic kick(input logic [31:0] b, input int l);
    ar_log.delete(); out_log.delete(); err_at_pop.delete();
    done_cnt = 0; busy_seen = 1'b0; busy_at_done = 1'bx; proto_err = 0;
    first_ar = -1; first_pop = -1; start_cyc = -1; done_cyc = -1;
    base_addr = b; len = 16'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (done_cnt == 0 && c < 600) begin @(posedge clk); #1; c++; end
    n_vec++;
    if (done_cnt == 0) begin n_fail++; $display("FAIL %s_timeout: no done within %0d cycles, expected one", name, c); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    ar_delay = 0; err_beat = -1; rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, err, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, out_valid, out_data, out_last} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b/%b/%b/%b/%h/%b/%b/%h/%b, expected all zero",
        busy, done, err, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, out_valid, out_data, out_last);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, M_AXI_ARVALID, out_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: busy/done/arvalid/out_valid=%b%b%b%b, expected 0000", busy, done, M_AXI_ARVALID, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] b = 32'h10;
    int l = 4;
    out_ready = 1'b1; ar_delay = 0; err_beat = -1;
    kick(b, l);
    wait_done("basic");
    n_vec++; if (out_log.size() != l) begin n_fail++; $display("FAIL basic_count: got %0d bytes, expected %0d", out_log.size(), l); end
    foreach (out_log[i]) begin
      n_vec++; if (out_log[i] !== ref_entry(b, l, i)) begin n_fail++; $display("FAIL basic_byte%0d: got %h, expected %h", i, out_log[i], ref_entry(b, l, i)); end
    end
    n_vec++; if (ar_log.size() != l) begin n_fail++; $display("FAIL basic_ar_count: got %0d, expected %0d", ar_log.size(), l); end
    foreach (ar_log[i]) begin
      n_vec++; if (ar_log[i] !== b + 32'(i)) begin n_fail++; $display("FAIL basic_araddr%0d: got %h, expected %h", i, ar_log[i], b + 32'(i)); end
    end
    n_vec++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses, expected 1", done_cnt); end
    n_vec++; if (first_ar - start_cyc != 1) begin n_fail++; $display("FAIL basic_ar_lat: got %0d, expected 1", first_ar - start_cyc); end
    n_vec++; if (first_pop - start_cyc != 3) begin n_fail++; $display("FAIL basic_out_lat: got %0d, expected 3", first_pop - start_cyc); end
    n_vec++; if (done_cyc - start_cyc != 2 * l + 2) begin n_fail++; $display("FAIL basic_done_lat: got %0d, expected %0d", done_cyc - start_cyc, 2 * l + 2); end
    n_vec++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b, expected 0", busy_at_done); end
    n_vec++; if (proto_err != 0) begin n_fail++; $display("FAIL basic_protocol: got %0d violations, expected 0", proto_err); end
  endtask

  task automatic test_len_zero();
    kick(32'h40, 0);
    wait_done("len0");
    n_vec++; if (done_cnt != 1) begin n_fail++; $display("FAIL len0_done: got %0d pulses, expected 1", done_cnt); end
    n_vec++; if (done_cyc - start_cyc != 1) begin n_fail++; $display("FAIL len0_done_lat: got %0d, expected 1", done_cyc - start_cyc); end
    n_vec++; if (ar_log.size() != 0 || out_log.size() != 0) begin n_fail++; $display("FAIL len0_traffic: got %0d ARs %0d bytes, expected 0 0", ar_log.size(), out_log.size()); end
    n_vec++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b, expected 0", busy_seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] b = 32'h80;
    int l = 8;
    out_ready = 1'b0;
    kick(b, l);
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (ar_log.size() > DEPTH || ar_log.size() == 0) begin n_fail++; $display("FAIL bp_ar_bound: got %0d ARs, expected 1..%0d", ar_log.size(), DEPTH); end
    n_vec++; if (out_valid !== 1'b1 || out_log.size() != 0) begin n_fail++; $display("FAIL bp_hold: out_valid=%b pops=%0d, expected 1 0", out_valid, out_log.size()); end
    out_ready = 1'b1;
    wait_done("bp");
    n_vec++; if (out_log.size() != l) begin n_fail++; $display("FAIL bp_count: got %0d bytes, expected %0d", out_log.size(), l); end
    foreach (out_log[i]) begin
      n_vec++; if (out_log[i] !== ref_entry(b, l, i)) begin n_fail++; $display("FAIL bp_byte%0d: got %h, expected %h", i, out_log[i], ref_entry(b, l, i)); end
    end
    n_vec++; if (ar_log.size() != l || done_cnt != 1) begin n_fail++; $display("FAIL bp_totals: got %0d ARs %0d dones, expected %0d 1", ar_log.size(), done_cnt, l); end
  endtask

  task automatic test_ar_delay();
    logic [31:0] b = 32'h20;
    int l = 3;
    ar_delay = 3;
    kick(b, l);
    wait_done("ardly");
    n_vec++; if (first_ar - start_cyc != 4) begin n_fail++; $display("FAIL ardly_first_ar: got %0d, expected 4", first_ar - start_cyc); end
    n_vec++; if (proto_err != 0) begin n_fail++; $display("FAIL ardly_stable: got %0d violations, expected 0", proto_err); end
    n_vec++; if (out_log.size() != l) begin n_fail++; $display("FAIL ardly_count: got %0d, expected %0d", out_log.size(), l); end
    foreach (out_log[i]) begin
      n_vec++; if (out_log[i] !== ref_entry(b, l, i)) begin n_fail++; $display("FAIL ardly_byte%0d: got %h, expected %h", i, out_log[i], ref_entry(b, l, i)); end
    end
    ar_delay = 0;
  endtask

  task automatic test_rresp_err();
    logic [31:0] b = 32'h30;
    int l = 4;
    out_ready = 1'b1; err_beat = 1;
    kick(b, l);
    wait_done("rresp");
    n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL rresp_err: got %b, expected 1", err); end
    n_vec++; if (out_log.size() != l) begin n_fail++; $display("FAIL rresp_count: got %0d, expected %0d", out_log.size(), l); end
    foreach (out_log[i]) begin
      n_vec++; if (out_log[i] !== ref_entry(b, l, i)) begin n_fail++; $display("FAIL rresp_byte%0d: got %h, expected %h", i, out_log[i], ref_entry(b, l, i)); end
      n_vec++; if (err_at_pop[i] !== (i >= err_beat)) begin n_fail++; $display("FAIL rresp_err_at_byte%0d: got %b, expected %b", i, err_at_pop[i], (i >= err_beat)); end
    end
    err_beat = -1;
    kick(32'h34, 2);
    n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rresp_clear: got %b, expected 0", err); end
    wait_done("rresp2");
    n_vec++; if (err !== 1'b0 || out_log.size() != 2) begin n_fail++; $display("FAIL rresp_clean_run: err=%b bytes=%0d, expected 0 2", err, out_log.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b = 32'h60;
    int l = 5;
    out_ready = 1'b1;
    kick(32'h50, 8);
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, err, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, out_valid, out_data, out_last} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: busy=%b arvalid=%b araddr=%h rready=%b out_valid=%b out_data=%h, expected zeros",
        busy, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, out_valid, out_data);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    kick(b, l);
    repeat (2) @(posedge clk);
    #1;
    base_addr = 32'h99; len = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("midrst");
    n_vec++; if (out_log.size() != l || ar_log.size() != l) begin n_fail++; $display("FAIL midrst_count: got %0d bytes %0d ARs, expected %0d", out_log.size(), ar_log.size(), l); end
    foreach (out_log[i]) begin
      n_vec++; if (out_log[i] !== ref_entry(b, l, i)) begin n_fail++; $display("FAIL midrst_byte%0d: got %h, expected %h", i, out_log[i], ref_entry(b, l, i)); end
    end
    n_vec++; if (done_cnt != 1) begin n_fail++; $display("FAIL midrst_done: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int l;
    rdy_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      b = (r == 0) ? 32'hFFFF_FFFD : $urandom;
      l = $urandom_range(1, 10);
      ar_delay = $urandom_range(0, 3);
      err_beat = $urandom_range(0, 12);
      kick(b, l);
      wait_done("rand");
      n_vec++; if (out_log.size() != l) begin n_fail++; $display("FAIL rand%0d_count: got %0d, expected %0d", r, out_log.size(), l); end
      foreach (out_log[i]) begin
        n_vec++; if (out_log[i] !== ref_entry(b, l, i)) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h, expected %h", r, i, out_log[i], ref_entry(b, l, i)); end
      end
      n_vec++; if (ar_log.size() != l) begin n_fail++; $display("FAIL rand%0d_ar_count: got %0d, expected %0d", r, ar_log.size(), l); end
      foreach (ar_log[i]) begin
        n_vec++; if (ar_log[i] !== b + 32'(i * STRIDE)) begin n_fail++; $display("FAIL rand%0d_araddr%0d: got %h, expected %h", r, i, ar_log[i], b + 32'(i * STRIDE)); end
      end
      n_vec++; if (err !== (err_beat < l)) begin n_fail++; $display("FAIL rand%0d_err: got %b, expected %b", r, err, (err_beat < l)); end
      n_vec++; if (done_cnt != 1 || proto_err != 0) begin n_fail++; $display("FAIL rand%0d_done_proto: got %0d dones %0d violations, expected 1 0", r, done_cnt, proto_err); end
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    ar_delay = 0;
    err_beat = -1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_ar_delay();
    test_rresp_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
